seq_chunk_adder_sub: RTL and testbench
======================================

// Module: seq_chunk_adder_sub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair
//  CHUNK bits per clock through one shared CHUNK-bit ripple-carry slice.
//  Sits between switch/register inputs and LED/display logic. Adds subtraction,
//  flags and valid/ready flow control, which the purely combinational adder lacks.
// PARAMETERS
//  WIDTH   8  operand/result width; WIDTH % CHUNK == 0 (elaboration-time $error otherwise)
//  CHUNK   2  bits summed per cycle; 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk        in   1      system clock (single clock domain)
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ADD only; ignored for SUB)
//  op         in   1      op_e: 0=OP_ADD (a+b+cin), 1=OP_SUB (a-b)
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out; for SUB 1 = no borrow (a >= b unsigned)
//  ovf        out  1      two's-complement signed overflow
//  zero       out  1      sum == 0
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): state=IDLE. in_ready=1.
//    out_valid, sum, cout, ovf, zero, busy are all 0. Internal chunk index is 0.
//  - Reset mid-operation aborts the operation. The partial result is discarded
//    and never presented.
//  - FSM IDLE -> CALC -> DONE -> IDLE. No other transitions.
//  - IDLE: in_ready=1. On in_valid && in_ready:
//      - latch A = a; B_eff = op ? ~b : b; carry = op ? 1 : cin
//      - latch sign bits a[W-1], B_eff[W-1]
//      - index = 0; go to CALC
//  - CALC: in_ready=0. Each cycle, slice index i:
//      - adds A[i*CHUNK +: CHUNK] + B_eff[same] + carry
//      - writes the result bits into the internal accumulator
//      - updates carry and increments index
//    After slice NCHUNK-1, go to DONE. Exactly NCHUNK cycles in CALC.
//  - DONE: out_valid=1. sum/cout/ovf/zero are registered and stable.
//    - ovf = (sA == sB_eff) && (sum[W-1] != sA)
//    - zero = ~|sum
//    - in_ready=0
//    - On out_ready: out_valid drops next cycle, go to IDLE. Outputs keep their
//      last value; only out_valid is qualifying.
//  - Latency: out_valid rises NCHUNK+1 edges after the accepting edge
//    (defaults: 5). Max throughput is 1 result per NCHUNK+2 cycles.
//  - No accept in the same cycle as a result hand-off (in_ready=0 in DONE).
//  - in_valid asserted while busy: ignored. Operands are not sampled; the
//    producer must hold them until in_ready.
//  - out_ready while not out_valid: no effect.
//  - NCHUNK=1 (CHUNK=WIDTH): one CALC cycle. Behaviour is otherwise identical.
// STRUCTURE
//  - Package adder_pkg:
//      - typedef enum logic {OP_ADD, OP_SUB} op_e
//      - typedef enum logic [1:0] {IDLE, CALC, DONE} adder_state_e
//  - Sub-module chunk_rca #(.W(CHUNK)): combinational W-bit ripple-carry slice
//    (a, b, cin -> s, cout), built from per-bit p/g full-adder cells.
//    Instantiated once.
//  - Top holds the FSM, index counter ($clog2(NCHUNK) bits, minimum 1),
//    operand/accumulator registers and flag registers.
// TESTING (WIDTH=8, CHUNK=2 unless noted)
//  1. ADD 0x3C+0x55, cin=0 -> sum=0x91, cout=0, ovf=1, zero=0; out_valid 5 edges after accept
//  2. ADD 0xFF+0x00, cin=1 -> sum=0x00, cout=1, ovf=0, zero=1
//  3. SUB 0x10-0x20 -> sum=0xF0, cout=0, ovf=0; SUB 0x80-0x01 -> sum=0x7F, cout=1, ovf=1
//  4. Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 ->
//     out_valid and result stable, in_ready=0, no new accept; then accept next op
//  5. Assert rst_n=0 during CALC cycle 2 -> all outputs 0 and IDLE immediately;
//     the next op (0x01+0x01) -> 0x02 with no stale carry
//  6. CHUNK=8 and CHUNK=1 builds, random 1000 ops vs reference model ->
//     exact match; latency 2 and 9 respectively

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared operation and FSM state types for the sequential chunked adder/subtractor,
// plus a helper sizing the chunk index counter.
package adder_pkg;
   typedef enum logic {OP_ADD, OP_SUB} op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} adder_state_e;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/chunk_rca.sv
// chunk_rca: W-bit combinational ripple-carry slice built from per-bit propagate/generate cells.
module chunk_rca #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W:0]   c;
   logic [W-1:0] p;
   logic [W-1:0] g;
   assign c[0] = cin;
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign p[i]   = a[i] ^ b[i];
      assign g[i]   = a[i] & b[i];
      assign s[i]   = p[i] ^ c[i];
      assign c[i+1] = g[i] | (p[i] & c[i]);
   end
   assign cout = c[W];
endmodule

// File: rtl/seq_chunk_adder_sub.sv
// seq_chunk_adder_sub: multi-cycle WIDTH-bit adder/subtractor reusing one CHUNK-bit ripple slice,
// with valid/ready handshakes and registered carry, overflow and zero flags.
module seq_chunk_adder_sub
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = idx_width(NCHUNK);
   if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("seq_chunk_adder_sub: WIDTH must be a positive multiple of CHUNK");
   end
   adder_state_e     state;
   adder_state_e     state_nx;
   op_e              op_sel;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic             carry;
   logic             sa;
   logic             sb;
   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic [CHUNK-1:0] cs;
   logic             c_out;
   logic             last;
   assign op_sel    = op_e'(op);
   assign last      = idx == IW'(NCHUNK - 1);
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? CALC : IDLE;
         CALC:    state_nx = last ? DONE : CALC;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // Select the operand chunk addressed by the index for the shared slice.
   always_comb begin
      ca = '0;
      cb = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx == IW'(k)) begin
            ca = a_r[k*CHUNK +: CHUNK];
            cb = b_r[k*CHUNK +: CHUNK];
         end
      end
   end
   chunk_rca #(.W(CHUNK)) u_rca (
      .a    (ca),
      .b    (cb),
      .cin  (carry),
      .s    (cs),
      .cout (c_out)
   );
   always_comb begin
      acc_nx = acc;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx == IW'(k)) acc_nx[k*CHUNK +: CHUNK] = cs;
      end
   end
   // Subtraction is a + ~b + 1; the inverted sign of b feeds the overflow rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_r   <= a;
         b_r   <= (op_sel == OP_SUB) ? ~b : b;
         carry <= (op_sel == OP_SUB) ? 1'b1 : cin;
         sa    <= a[WIDTH-1];
         sb    <= (op_sel == OP_SUB) ? ~b[WIDTH-1] : b[WIDTH-1];
         idx   <= '0;
      end else if (state == CALC) begin
         acc   <= acc_nx;
         carry <= c_out;
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            sum  <= acc_nx;
            cout <= c_out;
            ovf  <= (sa == sb) && (acc_nx[WIDTH-1] != sa);
            zero <= ~|acc_nx;
         end
      end
   end
endmodule

// File: tb/tb_seq_chunk_adder_sub.sv
// tb_seq_chunk_adder_sub: directed and randomized checks of the chunked adder/subtractor
// against an arithmetic reference model with a per-cycle compare process.
module tb_seq_chunk_adder_sub;
   parameter int CHUNK = 2;
   localparam int W = 8;
   localparam int N = W / CHUNK;
   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero, busy;
   logic [W-1:0] a, b, sum;
   int n_chk = 0;
   int n_err = 0;
   int m_phase = 0;
   int m_left = 0;
   int m_accepts = 0;
   logic [W+2:0] m_res = '0;
   logic [W+2:0] m_pend = '0;
   logic [W-1:0] corners [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
   always #5 clk = ~clk;
   seq_chunk_adder_sub #(.WIDTH(W), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // Result as {sum, cout, ovf, zero} from plain integer arithmetic.
   function automatic logic [W+2:0] ref_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic o);
      int sx, sy, r;
      logic [W:0] u;
      logic c, v;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (o) begin
         u = {1'b0, x} - {1'b0, y};
         c = x >= y;
         r = sx - sy;
      end else begin
         u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
         c = u[W];
         r = sx + sy + int'(ci);
      end
      v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return {u[W-1:0], c, v, u[W-1:0] == '0};
   endfunction
   // Model: accept in idle, N busy cycles, then hold the result until taken.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_left  = 0;
         m_res   = '0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            m_pend = ref_fn(a, b, cin, op);
            m_left = N;
            m_phase = 1;
            m_accepts++;
         end
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 2;
            m_res = m_pend;
         end
      end else if (out_ready) begin
         m_phase = 0;
      end
   end
   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("result", 32'({sum, cout, ovf, zero}), 32'(m_res));
   end
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic to);
      int n0;
      n0 = m_accepts;
      a = ta; b = tb_; cin = tc; op = to; in_valid = 1'b1;
      for (int k = 0; k < 64 && m_accepts == n0; k++) begin
         @(posedge clk); #1;
      end
      chk("accept", 32'(m_accepts - n0), 32'd1);
      in_valid = 1'b0;
   endtask
   task automatic wait_valid(input string nm);
      int lat;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      chk(nm, 32'(lat), 32'(N + 1));
   endtask
   task automatic expect_res(input string nm, input logic [W-1:0] s, input logic c, input logic v, input logic z);
      chk(nm, 32'({sum, cout, ovf, zero}), 32'({s, c, v, z}));
   endtask
   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask
   initial begin
      int n0, cyc, target;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
      chk("pin_add_3c_55", 32'(ref_fn(8'h3C, 8'h55, 1'b0, 1'b0)), 32'({8'h91, 1'b0, 1'b1, 1'b0}));
      chk("pin_add_ff_00", 32'(ref_fn(8'hFF, 8'h00, 1'b1, 1'b0)), 32'({8'h00, 1'b1, 1'b0, 1'b1}));
      chk("pin_sub_10_20", 32'(ref_fn(8'h10, 8'h20, 1'b1, 1'b1)), 32'({8'hF0, 1'b0, 1'b0, 1'b0}));
      chk("pin_sub_80_01", 32'(ref_fn(8'h80, 8'h01, 1'b0, 1'b1)), 32'({8'h7F, 1'b1, 1'b1, 1'b0}));
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", 32'({in_ready, out_valid, busy, sum, cout, ovf, zero}), 32'({1'b1, 2'b00, 8'h00, 3'b000}));
      rst_n = 1'b1;
      start_op(8'h3C, 8'h55, 1'b0, 1'b0);
      wait_valid("lat_add_3c_55");
      expect_res("add_3c_55", 8'h91, 1'b0, 1'b1, 1'b0);
      pop();
      start_op(8'hFF, 8'h00, 1'b1, 1'b0);
      wait_valid("lat_add_ff_00");
      expect_res("add_ff_00", 8'h00, 1'b1, 1'b0, 1'b1);
      pop();
      start_op(8'h10, 8'h20, 1'b1, 1'b1);
      wait_valid("lat_sub_10_20");
      expect_res("sub_10_20", 8'hF0, 1'b0, 1'b0, 1'b0);
      pop();
      start_op(8'h80, 8'h01, 1'b0, 1'b1);
      wait_valid("lat_sub_80_01");
      expect_res("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0);
      pop();
      start_op(8'h12, 8'h34, 1'b0, 1'b0);
      wait_valid("lat_bp");
      a = 8'h01; b = 8'h02; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
      n0 = m_accepts;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'({out_valid, in_ready}), 32'(2'b10));
         expect_res("bp_hold_result", 8'h46, 1'b0, 1'b0, 1'b0);
         chk("bp_no_accept", 32'(m_accepts), 32'(n0));
      end
      pop();
      start_op(8'h01, 8'h02, 1'b0, 1'b0);
      wait_valid("lat_after_bp");
      expect_res("after_bp", 8'h03, 1'b0, 1'b0, 1'b0);
      pop();
      start_op(8'hFF, 8'h01, 1'b1, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 32'({in_ready, out_valid, busy, sum, cout, ovf, zero}), 32'({1'b1, 2'b00, 8'h00, 3'b000}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_op(8'h01, 8'h01, 1'b0, 1'b0);
      wait_valid("lat_after_abort");
      expect_res("after_abort", 8'h02, 1'b0, 1'b0, 1'b0);
      pop();
      target = m_accepts + 1000;
      cyc = 0;
      while (m_accepts < target && cyc < 60000) begin
         @(posedge clk); #1;
         cyc++;
         out_ready = $urandom_range(0, 3) != 0;
         if (!(m_phase == 0 && in_valid)) begin
            in_valid = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            cin = 1'($urandom_range(0, 1));
            op = 1'($urandom_range(0, 1));
         end
      end
      chk("random_ops_done", 32'(m_accepts >= target), 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (N + 4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
